// File: rtl/exponent_scheduler.sv
// Round-robin scheduler sharing one exponent engine (ready/enable handshake) between NUM_REQ requesters.
// Optional WAIT_DONE watchdog with engine reset and err reporting: define EXP_SCHED_TIMEOUT_EN.
module exponent_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*32-1:0] req_x,
   input  logic [NUM_REQ*32-1:0] req_a,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    done,
   output logic [31:0]           result,
   output logic                  err,
   output logic                  busy,
   output logic                  eng_enable,
   output logic [31:0]           eng_x,
   output logic [31:0]           eng_a,
   input  logic [31:0]           eng_p,
   input  logic                  eng_ready,
   output logic                  eng_reset_n
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int SUM_W = IDX_W + 1;

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("exponent_scheduler: NUM_REQ must be 2..8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("exponent_scheduler: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE,
      ABORT,
      RESP
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [IDX_W-1:0]   win_q, win_d;
   logic [NUM_REQ-1:0] gnt_d, done_d;
   logic [31:0]        result_d, eng_x_d, eng_a_d;
   logic               err_d, busy_d, eng_enable_d, eng_reset_n_d;

   logic               found;
   logic [IDX_W-1:0]   pick;
   logic [SUM_W-1:0]   cand;
   logic [31:0]        x_arr [NUM_REQ];
   logic [31:0]        a_arr [NUM_REQ];

`ifdef EXP_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         x_arr[i] = req_x[32*i +: 32];
         a_arr[i] = req_a[32*i +: 32];
      end
   end

   // First pending requester at or above rr_q, wrapping past NUM_REQ-1.
   always_comb begin
      found = 1'b0;
      pick  = rr_q;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_q} + SUM_W'(k);
         if (cand >= SUM_W'(NUM_REQ)) cand = cand - SUM_W'(NUM_REQ);
         if (!found && req[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            pick  = cand[IDX_W-1:0];
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      win_d         = win_q;
      gnt_d         = gnt;
      done_d        = '0;
      result_d      = result;
      err_d         = 1'b0;
      busy_d        = busy;
      eng_enable_d  = 1'b0;
      eng_x_d       = eng_x;
      eng_a_d       = eng_a;
      eng_reset_n_d = 1'b1;
`ifdef EXP_SCHED_TIMEOUT_EN
      cnt_d         = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (found && eng_ready) begin
               win_d        = pick;
               gnt_d        = '0;
               gnt_d[pick]  = 1'b1;
               eng_x_d      = x_arr[pick];
               eng_a_d      = a_arr[pick];
               eng_enable_d = 1'b1;
               busy_d       = 1'b1;
               state_d      = ISSUE;
            end
         end
         ISSUE: state_d = WAIT_ACK;
         WAIT_ACK: begin
            if (!eng_ready) begin
               state_d = WAIT_DONE;
`ifdef EXP_SCHED_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         WAIT_DONE: begin
            if (eng_ready) begin
               result_d = eng_p;
               done_d   = gnt;
               state_d  = RESP;
            end
`ifdef EXP_SCHED_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               eng_reset_n_d = 1'b0;
               state_d       = ABORT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
`ifdef EXP_SCHED_TIMEOUT_EN
         ABORT: begin
            result_d = '0;
            err_d    = 1'b1;
            done_d   = gnt;
            state_d  = RESP;
         end
`endif
         RESP: begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            rr_d    = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: reset is synchronous, so it is tested inside the clocked block and never appears in the sensitivity list.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         win_q       <= '0;
         gnt         <= '0;
         done        <= '0;
         result      <= '0;
         err         <= 1'b0;
         busy        <= 1'b0;
         eng_enable  <= 1'b0;
         eng_x       <= '0;
         eng_a       <= '0;
         eng_reset_n <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q     <= state_d;
         rr_q        <= rr_d;
         win_q       <= win_d;
         gnt         <= gnt_d;
         done        <= done_d;
         result      <= result_d;
         err         <= err_d;
         busy        <= busy_d;
         eng_enable  <= eng_enable_d;
         eng_x       <= eng_x_d;
         eng_a       <= eng_a_d;
         eng_reset_n <= eng_reset_n_d;
      end
   end

`ifdef EXP_SCHED_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`endif

endmodule
